// File: rtl/ddr2_ui_responder.sv
// ddr2_ui_responder: BRAM-backed stand-in for a DDR2 controller user interface.
// Ports: clk/reset_n (async active-low); command push ddr_rd_wr_n_i/ddr_addr_i/ddr_af_we_i;
// write beat push ddr_data_i/ddr_mask_i/ddr_df_we_i; almost-full flags ddr_af_afull_o/ddr_df_afull_o;
// read return ddr_data_o/ddr_dvalid_o; calibration done ddr_phy_rdy_o; sticky overflow err_af_ovf_o/err_df_ovf_o.
module ddr2_ui_responder #(
  parameter int DATA_WIDTH    = 64,
  parameter int MEM_AWIDTH    = 8,
  parameter int AF_DEPTH_LOG2 = 4,
  parameter int DF_DEPTH_LOG2 = 5,
  parameter int AFULL_MARGIN  = 2,
  parameter int CAL_CYCLES    = 16,
  parameter int RD_LATENCY    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ddr_rd_wr_n_i,
  input  logic [30:0]               ddr_addr_i,
  input  logic                      ddr_af_we_i,
  input  logic [2*DATA_WIDTH-1:0]   ddr_data_i,
  input  logic [2*DATA_WIDTH/8-1:0] ddr_mask_i,
  input  logic                      ddr_df_we_i,
  output logic                      ddr_af_afull_o,
  output logic                      ddr_df_afull_o,
  output logic [2*DATA_WIDTH-1:0]   ddr_data_o,
  output logic                      ddr_dvalid_o,
  output logic                      ddr_phy_rdy_o,
  output logic                      err_af_ovf_o,
  output logic                      err_df_ovf_o
);
  localparam int UW  = 2 * DATA_WIDTH;
  localparam int MW  = UW / 8;
  localparam int AW  = AF_DEPTH_LOG2;
  localparam int FW  = DF_DEPTH_LOG2;
  localparam int AFD = 2 ** AW;
  localparam int DFD = 2 ** FW;
  localparam int CW  = $clog2(CAL_CYCLES + 1);
  typedef enum logic [1:0] {CAL, IDLE, WR_B1, RD_B1} state_t;
  state_t state_q;
  logic [CW-1:0] cal_q;
  logic rdy_q;
  logic [MEM_AWIDTH:0] af_mem [AFD];
  logic [UW+MW-1:0] df_mem [DFD];
  logic [UW-1:0] mem [2**(MEM_AWIDTH+1)];
  logic [AW-1:0] af_wp_q, af_rp_q;
  logic [FW-1:0] df_wp_q, df_rp_q;
  logic [AW:0] af_cnt_q, af_cnt_d;
  logic [FW:0] df_cnt_q, df_cnt_d;
  logic af_afull_q, df_afull_q, err_af_q, err_df_q;
  logic [MEM_AWIDTH-1:0] slot_q;
  logic v_q [RD_LATENCY];
  logic [UW-1:0] d_q [RD_LATENCY];
  logic [MEM_AWIDTH:0] af_head;
  logic [UW+MW-1:0] df_head;
  logic rd_go, wr_go, af_pop, df_pop, af_push, df_push, rd_issue;
  logic [MEM_AWIDTH:0] beat_idx;
  logic addr_unused;
  assign addr_unused = ^{ddr_addr_i[30:MEM_AWIDTH+2], ddr_addr_i[1:0]};
  assign af_head  = af_mem[af_rp_q];
  assign df_head  = df_mem[df_rp_q];
  // A write command only leaves the AF once both of its beats are waiting in the DF.
  assign rd_go    = state_q == IDLE && af_cnt_q != '0 && af_head[MEM_AWIDTH];
  assign wr_go    = state_q == IDLE && af_cnt_q != '0 && !af_head[MEM_AWIDTH] && df_cnt_q >= (FW+1)'(2);
  assign af_pop   = rd_go || wr_go;
  assign df_pop   = wr_go || state_q == WR_B1;
  assign rd_issue = rd_go || state_q == RD_B1;
  // Beat 0 addresses the slot at the AF head; beat 1 reuses the slot latched at pop time.
  assign beat_idx = {state_q == IDLE ? af_head[MEM_AWIDTH-1:0] : slot_q, state_q != IDLE};
  // A full FIFO still accepts a push in the same cycle it pops.
  assign af_push  = ddr_af_we_i && (af_cnt_q != (AW+1)'(AFD) || af_pop);
  assign df_push  = ddr_df_we_i && (df_cnt_q != (FW+1)'(DFD) || df_pop);
  assign af_cnt_d = af_cnt_q + (AW+1)'(af_push) - (AW+1)'(af_pop);
  assign df_cnt_d = df_cnt_q + (FW+1)'(df_push) - (FW+1)'(df_pop);
  always_ff @(posedge clk) begin
    if (af_push) af_mem[af_wp_q] <= {ddr_rd_wr_n_i, ddr_addr_i[MEM_AWIDTH+1:2]};
    if (df_push) df_mem[df_wp_q] <= {ddr_mask_i, ddr_data_i};
    for (int b = 0; b < MW; b++)
      if (df_pop && df_head[UW+b]) mem[beat_idx][8*b +: 8] <= df_head[8*b +: 8];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CAL;
      cal_q      <= '0;
      rdy_q      <= 1'b0;
      af_wp_q    <= '0;
      af_rp_q    <= '0;
      df_wp_q    <= '0;
      df_rp_q    <= '0;
      af_cnt_q   <= '0;
      df_cnt_q   <= '0;
      af_afull_q <= 1'b0;
      df_afull_q <= 1'b0;
      err_af_q   <= 1'b0;
      err_df_q   <= 1'b0;
      slot_q     <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
      end
    end else begin
      if (state_q == CAL) begin
        cal_q <= cal_q + 1'b1;
        if (cal_q == CW'(CAL_CYCLES - 1)) begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      end else begin
        state_q <= rd_go ? RD_B1 : wr_go ? WR_B1 : IDLE;
      end
      if (af_pop) slot_q <= af_head[MEM_AWIDTH-1:0];
      af_wp_q    <= af_wp_q + AW'(af_push);
      af_rp_q    <= af_rp_q + AW'(af_pop);
      df_wp_q    <= df_wp_q + FW'(df_push);
      df_rp_q    <= df_rp_q + FW'(df_pop);
      af_cnt_q   <= af_cnt_d;
      df_cnt_q   <= df_cnt_d;
      af_afull_q <= af_cnt_d >= (AW+1)'(AFD - AFULL_MARGIN);
      df_afull_q <= df_cnt_d >= (FW+1)'(DFD - AFULL_MARGIN);
      err_af_q   <= err_af_q | (ddr_af_we_i & ~af_push);
      err_df_q   <= err_df_q | (ddr_df_we_i & ~df_push);
      // Read pipe: stage 0 is the memory read; data stages only load on valid so the output holds.
      v_q[0] <= rd_issue;
      if (rd_issue) d_q[0] <= mem[beat_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end
  assign ddr_af_afull_o = af_afull_q;
  assign ddr_df_afull_o = df_afull_q;
  assign ddr_data_o     = d_q[RD_LATENCY-1];
  assign ddr_dvalid_o   = v_q[RD_LATENCY-1];
  assign ddr_phy_rdy_o  = rdy_q;
  assign err_af_ovf_o   = err_af_q;
  assign err_df_ovf_o   = err_df_q;
endmodule
